fetch_req_queue: RTL and testbench
==================================

// Module: fetch_req_queue
// PURPOSE
//  Sits directly downstream of pcgen and upstream of the icache. Buffers fetch-group PCs,
//  splits any group that crosses a cache line into two icache requests, and tags each
//  request with a unique id. Drives stall_out back to pcgen, sized for pcgen's 1-cycle
//  stall-to-effect delay. Discards all state on flush_in.
// PARAMETERS
//  DEPTH        4   queue entries (>=2, power of 2)
//  VADDR_WIDTH  39  virtual address width
//  ID_WIDTH     32  instruction-id width
//  NUM_OF_FETCH 4   instrs per group; GROUP_BYTES = 4*NUM_OF_FETCH
//  LINE_BYTES   64  icache line size (power of 2, > GROUP_BYTES)
// PORTS
//  clock          in   1              clock, rising edge
//  reset          in   1              asynchronous, active-low (0 = in reset)
//  pc_valid_in    in   1              pcgen output valid
//  pc_vaddr_in    in   VADDR_WIDTH    group start vaddr (4B aligned)
//  pc_id_in       in   ID_WIDTH       first_instr_id of group
//  flush_in       in   1              flush: drop queue and in-flight request
//  stall_out      out  1              to pcgen stall_in
//  ic_req_valid   out  1              icache request valid
//  ic_req_ready   in   1              icache accepts request
//  ic_req_vaddr   out  VADDR_WIDTH    request start vaddr
//  ic_req_nbytes  out  $clog2(GROUP_BYTES)+1  bytes requested (4..GROUP_BYTES)
//  ic_req_id      out  ID_WIDTH       request id
//  ic_req_last    out  1              final request of this group
//  overflow_err   out  1              sticky: valid PC arrived while full
// BEHAVIOUR
//  Reset (reset=0, async): queue empty, FSM IDLE; all outputs 0 immediately.
//  Enqueue: pc_valid_in & !flush_in & (count<DEPTH | pop this cycle). If full with no
//   pop, drop PC and set overflow_err (held until reset).
//  stall_out = (count >= DEPTH-1), combinational from registered count only.
//   Covers the one valid PC pcgen emits in the cycle after it sees stall.
//  off = vaddr mod LINE_BYTES; cross = off + GROUP_BYTES > LINE_BYTES.
//  FSM (ic_req_* registered):
//   IDLE: if head exists, load REQ0 next edge.
//   REQ0: vaddr=head.vaddr; nbytes = cross ? LINE_BYTES-off : GROUP_BYTES;
//     id=head.id; last=!cross.
//   REQ1: vaddr = line base + LINE_BYTES (wraps mod 2^VADDR_WIDTH);
//     nbytes = GROUP_BYTES-(LINE_BYTES-off); id = head.id+1 (mod 2^ID_WIDTH); last=1.
//   On valid&ready, REQ0 goes to REQ1 if cross. Otherwise pop the head and either
//    load REQ0 of the next entry on the same edge (1 req/cycle) or go IDLE.
//   REQ1 accepted: pop, then load next REQ0 or go IDLE.
//  Handshake: once ic_req_valid=1, vaddr/nbytes/id/last stay stable until ready. The
//   only exceptions are flush and reset.
//  Latency: a PC enqueued into an empty queue at edge t is driven from edge t+1.
//  Flush: on the flush_in edge, count=0, FSM=IDLE, ic_req_valid=0. A same-cycle
//   pc_valid_in is dropped. A same-cycle ready is ignored; the request counts as cancelled.
//  Flush & stall_out: after flush, count=0, so stall_out=0 next cycle.
//  Simultaneous enqueue and pop at count=DEPTH: allowed, count unchanged.
//  Pointers wrap mod DEPTH. count ranges 0..DEPTH.
// TESTING
//  1. Reset; PC 0x8000_0000 id 0, ready=1 -> next cycle: vaddr 0x8000_0000,
//     nbytes 16, id 0, last 1; stall_out 0.
//  2. PC 0x8000_0038 id 8 -> REQ0 vaddr ..0038 nbytes 8 id 8 last 0; then REQ1
//     vaddr ..0040 nbytes 8 id 9 last 1.
//  3. ready=0, 4 consecutive PCs -> stall_out rises when count=3, count reaches 4,
//     no overflow_err. Then ready=1 -> 4 requests issued back-to-back in order.
//  4. Flush while REQ1 pending with ready=1 the same cycle -> valid=0 next cycle,
//     count 0; next PC 0x8000_1000 is issued as a fresh REQ0.
//  5. Force a valid PC while full with ready=0 -> overflow_err=1, sticky; queue
//     contents unchanged.
//  6. Assert reset low mid-REQ1 -> all outputs 0 with no clock edge. After release,
//     normal operation from an empty queue.

Source files
------------

// File: rtl/fetch_req_queue_if.sv
// Fetch request bundle: pcgen -> fetch_req_queue (PC side) and fetch_req_queue -> icache
// (request side). The queue uses the master modport; pcgen/icache models use slave.
interface fetch_req_queue_if #(
    parameter int VADDR_WIDTH  = 39,
    parameter int ID_WIDTH     = 32,
    parameter int NUM_OF_FETCH = 4
);
    localparam int GROUP_BYTES = 4 * NUM_OF_FETCH;
    localparam int NB_WIDTH    = $clog2(GROUP_BYTES) + 1;

    logic                   pc_valid_in;
    logic [VADDR_WIDTH-1:0] pc_vaddr_in;
    logic [ID_WIDTH-1:0]    pc_id_in;
    logic                   stall_out;
    logic                   ic_req_valid;
    logic                   ic_req_ready;
    logic [VADDR_WIDTH-1:0] ic_req_vaddr;
    logic [NB_WIDTH-1:0]    ic_req_nbytes;
    logic [ID_WIDTH-1:0]    ic_req_id;
    logic                   ic_req_last;

    modport master (
        input  pc_valid_in,
        input  pc_vaddr_in,
        input  pc_id_in,
        input  ic_req_ready,
        output stall_out,
        output ic_req_valid,
        output ic_req_vaddr,
        output ic_req_nbytes,
        output ic_req_id,
        output ic_req_last
    );

    modport slave (
        output pc_valid_in,
        output pc_vaddr_in,
        output pc_id_in,
        output ic_req_ready,
        input  stall_out,
        input  ic_req_valid,
        input  ic_req_vaddr,
        input  ic_req_nbytes,
        input  ic_req_id,
        input  ic_req_last
    );
endinterface

// File: rtl/fetch_req_queue.sv
// Fetch request queue: buffers fetch-group PCs from pcgen, splits groups that cross an
// icache line into two tagged requests, and back-pressures pcgen through stall_out.
module fetch_req_queue #(
    parameter int DEPTH        = 4,
    parameter int VADDR_WIDTH  = 39,
    parameter int ID_WIDTH     = 32,
    parameter int NUM_OF_FETCH = 4,
    parameter int LINE_BYTES   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_in,
    output logic              overflow_err,
    fetch_req_queue_if.master req_if
);

    localparam int GROUP_BYTES = 4 * NUM_OF_FETCH;
    localparam int NB_WIDTH    = $clog2(GROUP_BYTES) + 1;
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1);
    localparam int LINE_WIDTH  = $clog2(LINE_BYTES);
    localparam int OFF_WIDTH   = LINE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   head_q, head_d;
    logic [PTR_WIDTH-1:0]   tail_q, tail_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [VADDR_WIDTH-1:0] vaddr_mem_q [DEPTH];
    logic [VADDR_WIDTH-1:0] vaddr_mem_d [DEPTH];
    logic [ID_WIDTH-1:0]    id_mem_q [DEPTH];
    logic [ID_WIDTH-1:0]    id_mem_d [DEPTH];
    logic                   req_valid_q, req_valid_d;
    logic [VADDR_WIDTH-1:0] req_vaddr_q, req_vaddr_d;
    logic [NB_WIDTH-1:0]    req_nbytes_q, req_nbytes_d;
    logic [ID_WIDTH-1:0]    req_id_q, req_id_d;
    logic                   req_last_q, req_last_d;
    logic                   overflow_q, overflow_d;

    logic                   accept;
    logic                   pop;
    logic                   push;
    logic                   full;
    logic                   advance;
    logic                   load_ok;
    logic [VADDR_WIDTH-1:0] load_vaddr;
    logic [ID_WIDTH-1:0]    load_id;
    logic [OFF_WIDTH-1:0]   load_off;
    logic                   load_cross;
    logic [NB_WIDTH-1:0]    load_nbytes;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            req_valid_q  <= 1'b0;
            req_vaddr_q  <= '0;
            req_nbytes_q <= '0;
            req_id_q     <= '0;
            req_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                vaddr_mem_q[i] <= '0;
                id_mem_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            req_valid_q  <= req_valid_d;
            req_vaddr_q  <= req_vaddr_d;
            req_nbytes_q <= req_nbytes_d;
            req_id_q     <= req_id_d;
            req_last_q   <= req_last_d;
            overflow_q   <= overflow_d;
            vaddr_mem_q  <= vaddr_mem_d;
            id_mem_q     <= id_mem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        vaddr_mem_d  = vaddr_mem_q;
        id_mem_d     = id_mem_q;
        req_valid_d  = req_valid_q;
        req_vaddr_d  = req_vaddr_q;
        req_nbytes_d = req_nbytes_q;
        req_id_d     = req_id_q;
        req_last_d   = req_last_q;
        overflow_d   = overflow_q;

        // The head entry leaves the queue only when its last request is accepted.
        accept = req_valid_q & req_if.ic_req_ready & ~flush_in;
        pop    = accept & req_last_q;
        full   = (count_q == CNT_WIDTH'(DEPTH));
        push   = req_if.pc_valid_in & ~flush_in & (~full | pop);

        if (req_if.pc_valid_in & ~flush_in & full & ~pop) begin
            overflow_d = 1'b1;
        end

        if (push) begin
            vaddr_mem_d[tail_q] = req_if.pc_vaddr_in;
            id_mem_d[tail_q]    = req_if.pc_id_in;
            tail_d              = tail_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_WIDTH'(1);
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

        // Next REQ0 comes from an entry already stored, never from a same-cycle push.
        load_ok     = pop ? (count_q > CNT_WIDTH'(1)) : (count_q != '0);
        load_vaddr  = vaddr_mem_q[head_d];
        load_id     = id_mem_q[head_d];
        load_off    = {1'b0, load_vaddr[LINE_WIDTH-1:0]};
        load_cross  = (load_off + OFF_WIDTH'(GROUP_BYTES)) > OFF_WIDTH'(LINE_BYTES);
        load_nbytes = load_cross ? NB_WIDTH'(OFF_WIDTH'(LINE_BYTES) - load_off)
                                 : NB_WIDTH'(GROUP_BYTES);

        case (state_q)
            IDLE:    advance = 1'b1;
            REQ0:    advance = pop;
            REQ1:    advance = accept;
            default: advance = 1'b1;
        endcase

        if ((state_q == REQ0) && accept && !req_last_q) begin
            state_d      = REQ1;
            req_valid_d  = 1'b1;
            req_vaddr_d  = {req_vaddr_q[VADDR_WIDTH-1:LINE_WIDTH], {LINE_WIDTH{1'b0}}}
                           + VADDR_WIDTH'(LINE_BYTES);
            req_nbytes_d = NB_WIDTH'(GROUP_BYTES) - req_nbytes_q;
            req_id_d     = req_id_q + ID_WIDTH'(1);
            req_last_d   = 1'b1;
        end else if (advance) begin
            if (load_ok) begin
                state_d      = REQ0;
                req_valid_d  = 1'b1;
                req_vaddr_d  = load_vaddr;
                req_nbytes_d = load_nbytes;
                req_id_d     = load_id;
                req_last_d   = ~load_cross;
            end else begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        end

        if (flush_in) begin
            state_d     = IDLE;
            req_valid_d = 1'b0;
            count_d     = '0;
            head_d      = '0;
            tail_d      = '0;
        end
    end

    // Raised one entry early because pcgen still emits one PC after seeing stall.
    assign req_if.stall_out     = (count_q >= CNT_WIDTH'(DEPTH - 1));
    assign req_if.ic_req_valid  = req_valid_q;
    assign req_if.ic_req_vaddr  = req_vaddr_q;
    assign req_if.ic_req_nbytes = req_nbytes_q;
    assign req_if.ic_req_id     = req_id_q;
    assign req_if.ic_req_last   = req_last_q;
    assign overflow_err         = overflow_q;

endmodule

// File: tb/tb_fetch_req_queue.sv
// Bench for fetch_req_queue: directed steps then randomized traffic, every cycle checked
// against a reference model that tracks the expected icache request stream.
module tb_fetch_req_queue;

    localparam int DEPTH = 4;
    localparam int VA    = 39;
    localparam int IDW   = 32;
    localparam int NB    = 5;
    localparam int LINE  = 64;
    localparam int GROUP = 16;

    logic clock = 1'b0;
    logic reset;
    logic flush_in;
    logic overflow_err;

    fetch_req_queue_if #(.VADDR_WIDTH(VA), .ID_WIDTH(IDW), .NUM_OF_FETCH(4)) bus ();

    fetch_req_queue #(
        .DEPTH(DEPTH), .VADDR_WIDTH(VA), .ID_WIDTH(IDW), .NUM_OF_FETCH(4), .LINE_BYTES(LINE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flush_in(flush_in),
        .overflow_err(overflow_err),
        .req_if(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [VA-1:0]  vaddr;
        logic [NB-1:0]  nbytes;
        logic [IDW-1:0] id;
        logic           last;
    } req_t;

    // Model: flattened stream of expected requests, number of queued groups, and whether
    // the front request is currently being presented to the icache.
    req_t exp_q[$];
    int   m_groups;
    bit   m_present;
    bit   m_overflow;
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        m_groups   = 0;
        m_present  = 1'b0;
        m_overflow = 1'b0;
    endtask

    task automatic modelPush(input logic [VA-1:0] vaddr, input logic [IDW-1:0] id);
        req_t r;
        int   off;
        off = int'(vaddr % VA'(LINE));
        if (off + GROUP > LINE) begin
            r.vaddr = vaddr; r.nbytes = NB'(LINE - off); r.id = id; r.last = 1'b0;
            exp_q.push_back(r);
            r.vaddr = vaddr - VA'(off) + VA'(LINE);
            r.nbytes = NB'(GROUP - (LINE - off)); r.id = id + 1; r.last = 1'b1;
            exp_q.push_back(r);
        end else begin
            r.vaddr = vaddr; r.nbytes = NB'(GROUP); r.id = id; r.last = 1'b1;
            exp_q.push_back(r);
        end
        m_groups++;
    endtask

    task automatic modelStep(input bit v, input logic [VA-1:0] addr, input logic [IDW-1:0] id,
                             input bit rdy, input bit fl);
        bit accepted;
        bit popped;
        bit do_push;
        int old_groups;
        if (fl) begin
            exp_q.delete();
            m_groups  = 0;
            m_present = 1'b0;
        end else begin
            accepted   = m_present && rdy;
            popped     = accepted && exp_q[0].last;
            old_groups = m_groups;
            do_push    = 1'b0;
            if (v) begin
                if (old_groups < DEPTH || popped) do_push = 1'b1;
                else m_overflow = 1'b1;
            end
            if (accepted) void'(exp_q.pop_front());
            if (popped) m_groups--;
            if (accepted && !popped) m_present = 1'b1;
            else if (accepted) m_present = (m_groups > 0);
            else if (!m_present) m_present = (old_groups > 0);
            if (do_push) modelPush(addr, id);
        end
    endtask

    task automatic checkModel(input string ctx);
        checkOutput({ctx, ".valid"}, 64'(bus.ic_req_valid), 64'(m_present));
        checkOutput({ctx, ".stall"}, 64'(bus.stall_out), 64'(m_groups >= DEPTH - 1));
        checkOutput({ctx, ".ovf"}, 64'(overflow_err), 64'(m_overflow));
        if (m_present) begin
            checkOutput({ctx, ".vaddr"}, 64'(bus.ic_req_vaddr), 64'(exp_q[0].vaddr));
            checkOutput({ctx, ".nbytes"}, 64'(bus.ic_req_nbytes), 64'(exp_q[0].nbytes));
            checkOutput({ctx, ".id"}, 64'(bus.ic_req_id), 64'(exp_q[0].id));
            checkOutput({ctx, ".last"}, 64'(bus.ic_req_last), 64'(exp_q[0].last));
        end
    endtask

    task automatic applyStimulus(input string ctx, input bit v, input logic [VA-1:0] addr,
                                 input logic [IDW-1:0] id, input bit rdy, input bit fl);
        bus.pc_valid_in  = v;
        bus.pc_vaddr_in  = addr;
        bus.pc_id_in     = id;
        bus.ic_req_ready = rdy;
        flush_in         = fl;
        @(posedge clock);
        modelStep(v, addr, id, rdy, fl);
        #1;
        checkModel(ctx);
    endtask

    task automatic applyReset(input string ctx);
        bus.pc_valid_in  = 1'b0;
        bus.pc_vaddr_in  = '0;
        bus.pc_id_in     = '0;
        bus.ic_req_ready = 1'b0;
        flush_in         = 1'b0;
        reset            = 1'b0;
        #2;
        checkOutput({ctx, ".valid"}, 64'(bus.ic_req_valid), 64'h0);
        checkOutput({ctx, ".vaddr"}, 64'(bus.ic_req_vaddr), 64'h0);
        checkOutput({ctx, ".nbytes"}, 64'(bus.ic_req_nbytes), 64'h0);
        checkOutput({ctx, ".id"}, 64'(bus.ic_req_id), 64'h0);
        checkOutput({ctx, ".last"}, 64'(bus.ic_req_last), 64'h0);
        checkOutput({ctx, ".stall"}, 64'(bus.stall_out), 64'h0);
        checkOutput({ctx, ".ovf"}, 64'(overflow_err), 64'h0);
        modelReset();
        #2;
        reset = 1'b1;
    endtask

    task automatic checkReq(input string ctx, input logic [63:0] vaddr, input logic [63:0] nbytes,
                            input logic [63:0] id, input logic [63:0] last);
        checkOutput({ctx, ".valid"}, 64'(bus.ic_req_valid), 64'h1);
        checkOutput({ctx, ".vaddr"}, 64'(bus.ic_req_vaddr), vaddr);
        checkOutput({ctx, ".nbytes"}, 64'(bus.ic_req_nbytes), nbytes);
        checkOutput({ctx, ".id"}, 64'(bus.ic_req_id), id);
        checkOutput({ctx, ".last"}, 64'(bus.ic_req_last), last);
    endtask

    initial begin
        logic [VA-1:0]  a;
        logic [IDW-1:0] idv;
        bit             v;
        bit             rdy;
        bit             fl;
        bit             prev_stall;

        applyReset("rst0");

        // Single non-crossing group, one-cycle latency from an empty queue.
        applyStimulus("t1.push", 1, 39'h8000_0000, 32'd0, 1, 0);
        applyStimulus("t1.req", 0, '0, '0, 1, 0);
        checkReq("t1.req", 64'h8000_0000, 64'd16, 64'd0, 64'd1);
        checkOutput("t1.stall", 64'(bus.stall_out), 64'h0);

        // Line-crossing group splits into REQ0/REQ1.
        applyStimulus("t2.push", 1, 39'h8000_0038, 32'd8, 1, 0);
        applyStimulus("t2.req0", 0, '0, '0, 0, 0);
        checkReq("t2.req0", 64'h8000_0038, 64'd8, 64'd8, 64'd0);
        applyStimulus("t2.req1", 0, '0, '0, 1, 0);
        checkReq("t2.req1", 64'h8000_0040, 64'd8, 64'd9, 64'd1);
        applyStimulus("t2.done", 0, '0, '0, 1, 0);

        // Fill with ready low, then overflow attempt, then back-to-back drain.
        applyStimulus("t3.p0", 1, 39'h8000_2000, 32'd16, 0, 0);
        applyStimulus("t3.p1", 1, 39'h8000_2010, 32'd20, 0, 0);
        checkOutput("t3.stall2", 64'(bus.stall_out), 64'h0);
        applyStimulus("t3.p2", 1, 39'h8000_2020, 32'd24, 0, 0);
        checkOutput("t3.stall3", 64'(bus.stall_out), 64'h1);
        applyStimulus("t3.p3", 1, 39'h8000_2030, 32'd28, 0, 0);
        checkOutput("t3.noovf", 64'(overflow_err), 64'h0);
        applyStimulus("t5.ovf", 1, 39'h8000_2040, 32'd99, 0, 0);
        checkOutput("t5.ovf", 64'(overflow_err), 64'h1);
        checkReq("t5.head", 64'h8000_2000, 64'd16, 64'd16, 64'd1);
        applyStimulus("t5.sticky", 0, '0, '0, 0, 0);
        checkOutput("t5.sticky", 64'(overflow_err), 64'h1);
        applyStimulus("t3.d1", 0, '0, '0, 1, 0);
        checkOutput("t3.id20", 64'(bus.ic_req_id), 64'd20);
        applyStimulus("t3.d2", 0, '0, '0, 1, 0);
        checkOutput("t3.id24", 64'(bus.ic_req_id), 64'd24);
        applyStimulus("t3.d3", 0, '0, '0, 1, 0);
        checkOutput("t3.id28", 64'(bus.ic_req_id), 64'd28);
        applyStimulus("t3.d4", 0, '0, '0, 1, 0);
        checkOutput("t3.empty", 64'(bus.ic_req_valid), 64'h0);

        // Flush with REQ1 pending and ready high the same cycle.
        applyStimulus("t4.push", 1, 39'h8000_0038, 32'd40, 0, 0);
        applyStimulus("t4.req0", 0, '0, '0, 0, 0);
        applyStimulus("t4.req1", 0, '0, '0, 1, 0);
        applyStimulus("t4.flush", 1, 39'h8000_3000, 32'd44, 1, 1);
        checkOutput("t4.valid", 64'(bus.ic_req_valid), 64'h0);
        checkOutput("t4.stall", 64'(bus.stall_out), 64'h0);
        applyStimulus("t4.push2", 1, 39'h8000_1000, 32'd50, 0, 0);
        applyStimulus("t4.req", 0, '0, '0, 0, 0);
        checkReq("t4.req", 64'h8000_1000, 64'd16, 64'd50, 64'd1);
        applyStimulus("t4.done", 0, '0, '0, 1, 0);

        // Full queue with simultaneous push and pop keeps count and raises no error.
        applyReset("rst1");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("full.fill", 1, VA'(39'h8000_4000 + 16 * i), IDW'(60 + i), 0, 0);
        end
        applyStimulus("full.pushpop", 1, 39'h8000_4100, 32'd70, 1, 0);
        checkOutput("full.noovf", 64'(overflow_err), 64'h0);
        checkOutput("full.stall", 64'(bus.stall_out), 64'h1);
        for (int i = 0; i < 6; i++) applyStimulus("full.drain", 0, '0, '0, 1, 0);

        // Address and id wrap, then async reset while REQ1 is pending.
        applyStimulus("wrap.push", 1, 39'h7F_FFFF_FFFC, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("wrap.req0", 0, '0, '0, 0, 0);
        checkReq("wrap.req0", 64'h7F_FFFF_FFFC, 64'd4, 64'hFFFF_FFFF, 64'd0);
        applyStimulus("wrap.req1", 0, '0, '0, 1, 0);
        checkReq("wrap.req1", 64'h0, 64'd12, 64'h0, 64'd1);
        applyReset("t6.rst");
        applyStimulus("t6.push", 1, 39'h8000_0010, 32'd5, 1, 0);
        applyStimulus("t6.req", 0, '0, '0, 1, 0);
        checkReq("t6.req", 64'h8000_0010, 64'd16, 64'd5, 64'd1);

        // Randomized traffic; alternating windows where pcgen honours stall with its delay.
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 900 == 899) applyReset("rnd.rst");
            a = VA'({$urandom(), $urandom()});
            a[1:0] = 2'b00;
            case ($urandom_range(0, 3))
                0: a[5:2] = 4'($urandom_range(12, 15));
                1: a = 39'h7F_FFFF_FFC0 | VA'($urandom_range(0, 15) * 4);
                2: a = 39'h8000_0000 + VA'($urandom_range(0, 255) * 4);
                default: ;
            endcase
            idv = $urandom();
            v   = ($urandom_range(0, 2) != 0);
            if (((cyc / 250) % 2) == 0 && prev_stall) v = 1'b0;
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            applyStimulus("rnd", v, a, idv, rdy, fl);
            prev_stall = bus.stall_out;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
